// File: rtl/zf_stream_to_host_pkg.sv
// rtl/zf_stream_to_host_pkg.sv - shared Zynq FIFO defines: states, AXI defaults, debug bit map
package zf_stream_to_host_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_MEM  = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DROP      = 3'd4,
        ST_DONE      = 3'd5
    } zf_state_t;

    localparam logic [2:0] ZF_PROT_DEFAULT = 3'b010;
    localparam logic [7:0] ZF_WSTRB_FULL   = 8'hFF;

    // Debug bit map, shared with the host-to-stream reader
    localparam int DBG_STATE_LSB = 0;
    localparam int DBG_ERR       = 3;
    localparam int DBG_MEM_VALID = 4;
    localparam int DBG_MEM_ACK   = 5;
    localparam int DBG_AWVALID   = 6;
    localparam int DBG_AWREADY   = 7;
    localparam int DBG_WVALID    = 8;
    localparam int DBG_WREADY    = 9;
    localparam int DBG_BVALID    = 10;
    localparam int DBG_TVALID    = 11;
    localparam int DBG_LCNT_LSB  = 12;

    // The host expects the two 32-bit halves of each stream word in the opposite order
    function automatic logic [63:0] swap_words(input logic [63:0] d);
        return {d[31:0], d[63:32]};
    endfunction

endpackage

// File: rtl/zf_stream_to_host.sv
// rtl/zf_stream_to_host.sv - AXI-stream to host DDR line writer, single outstanding AXI write
module zf_stream_to_host
    import zf_stream_to_host_pkg::*;
#(
    parameter logic [2:0]  PROT      = ZF_PROT_DEFAULT,
    parameter logic [15:0] MAX_LINES = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    output logic [31:0] AXI_AWADDR,
    output logic [2:0]  AXI_AWPROT,
    output logic        AXI_AWVALID,
    input  logic        AXI_AWREADY,
    output logic [63:0] AXI_WDATA,
    output logic [7:0]  AXI_WSTRB,
    output logic        AXI_WVALID,
    input  logic        AXI_WREADY,
    input  logic [1:0]  AXI_BRESP,
    input  logic        AXI_BVALID,
    output logic        AXI_BREADY,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic [31:0] mem_addr,
    input  logic        mem_valid,
    output logic        mem_ack,
    output logic [31:0] debug
);

    zf_state_t   state, state_nxt;
    logic [31:0] base_addr;
    logic [63:0] line;
    logic [15:0] line_count;
    logic        last, err, aw_done, w_done;
    logic        aw_fire, w_fire, b_fire, t_fire;

    assign AXI_AWADDR = base_addr;
    assign AXI_AWPROT = PROT;
    assign AXI_WDATA  = line;
    assign AXI_WSTRB  = ZF_WSTRB_FULL;

    assign aw_fire = AXI_AWVALID && AXI_AWREADY;
    assign w_fire  = AXI_WVALID && AXI_WREADY;
    assign b_fire  = AXI_BVALID && AXI_BREADY;
    assign t_fire  = i_tvalid && i_tready;

    always_comb begin
        state_nxt   = state;
        AXI_AWVALID = 1'b0;
        AXI_WVALID  = 1'b0;
        AXI_BREADY  = 1'b0;
        i_tready    = 1'b0;
        mem_ack     = 1'b0;
        case (state)
            ST_WAIT_MEM:  if (mem_valid) state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                i_tready = enb;
                if (i_tvalid) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                AXI_AWVALID = enb && !aw_done;
                AXI_WVALID  = enb && !w_done;
                // Both channels may finish together; leave as soon as neither is outstanding
                if ((aw_done || (AXI_AWVALID && AXI_AWREADY)) &&
                    (w_done  || (AXI_WVALID  && AXI_WREADY)))
                    state_nxt = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                AXI_BREADY = enb;
                if (AXI_BVALID) begin
                    if (last)                                 state_nxt = ST_DONE;
                    else if ((line_count + 16'd1) == MAX_LINES) state_nxt = ST_DROP;
                    else                                      state_nxt = ST_WAIT_DATA;
                end
            end
            ST_DROP: begin
                i_tready = enb;
                if (i_tvalid && i_tlast) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                mem_ack   = enb;
                state_nxt = ST_WAIT_MEM;
            end
            default: state_nxt = ST_WAIT_MEM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WAIT_MEM;
            base_addr  <= '0;
            line       <= '0;
            line_count <= '0;
            last       <= 1'b0;
            err        <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else if (enb) begin
            state <= state_nxt;
            case (state)
                ST_WAIT_MEM: begin
                    base_addr  <= mem_addr;
                    line_count <= '0;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                    err        <= 1'b0;
                end
                ST_WAIT_DATA: if (t_fire) begin
                    line <= swap_words(i_tdata);
                    last <= i_tlast;
                end
                ST_WRITE: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                ST_WAIT_RESP: if (b_fire) begin
                    err        <= err | (AXI_BRESP != 2'b00);
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                    base_addr  <= base_addr + 32'd8;
                    line_count <= line_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        debug                              = '0;
        debug[DBG_STATE_LSB +: 3]          = state;
        debug[DBG_ERR]                     = err;
        debug[DBG_MEM_VALID]               = mem_valid;
        debug[DBG_MEM_ACK]                 = mem_ack;
        debug[DBG_AWVALID]                 = AXI_AWVALID;
        debug[DBG_AWREADY]                 = AXI_AWREADY;
        debug[DBG_WVALID]                  = AXI_WVALID;
        debug[DBG_WREADY]                  = AXI_WREADY;
        debug[DBG_BVALID]                  = AXI_BVALID;
        debug[DBG_TVALID]                  = i_tvalid;
        debug[DBG_LCNT_LSB +: 16]          = line_count;
    end

endmodule
